// File: rtl/mcu_spi_slave.sv
// SPI mode-0 slave: receives MCU bytes in the clk domain and presents them as a byte strobe
// with a start-of-transaction flag; shifts a status byte back to the MCU on MISO.
module mcu_spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_csn,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    input  logic [7:0] miso_data,
    output logic       data_out_strobe,
    output logic       data_out_start,
    output logic [7:0] data_out
);

    logic [SYNC_STAGES-1:0] r_csn_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;

    logic w_csn_s;
    logic w_sclk_s;
    logic w_mosi_s;

    // History flops; the edge pulses are registered, so these line up with them in time.
    logic r_csn_h;
    logic r_sclk_h;
    logic r_mosi_h;
    logic r_rise;
    logic r_fall;
    logic r_csn_fall;

    logic       w_csn_low;
    logic [7:0] w_tx_next;

    logic [2:0] r_bit_cnt;
    logic       r_first;
    logic [6:0] r_rx_shift;
    logic [7:0] r_tx_shift;
    logic [7:0] r_data;
    logic       r_strobe;
    logic       r_start;
    logic       r_miso;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_csn_sync  <= '1;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
        end else begin
            r_csn_sync[0]  <= spi_csn;
            r_sclk_sync[0] <= spi_sclk;
            r_mosi_sync[0] <= spi_mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_csn_sync[i]  <= r_csn_sync[i-1];
                r_sclk_sync[i] <= r_sclk_sync[i-1];
                r_mosi_sync[i] <= r_mosi_sync[i-1];
            end
        end
    end

    assign w_csn_s  = r_csn_sync[SYNC_STAGES-1];
    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_csn_h    <= 1'b1;
            r_sclk_h   <= 1'b0;
            r_mosi_h   <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_csn_fall <= 1'b0;
        end else begin
            r_csn_h    <= w_csn_s;
            r_sclk_h   <= w_sclk_s;
            r_mosi_h   <= w_mosi_s;
            r_rise     <= w_sclk_s & ~r_sclk_h;
            r_fall     <= ~w_sclk_s & r_sclk_h;
            r_csn_fall <= ~w_csn_s & r_csn_h;
        end
    end

    assign w_csn_low = ~r_csn_h;

    // A fall with bit_cnt==0 follows a completed byte, so the next status byte is loaded there.
    always_comb begin
        w_tx_next = r_tx_shift;
        if (r_csn_fall) begin
            w_tx_next = miso_data;
        end else if (w_csn_low && r_fall) begin
            if (r_bit_cnt != 3'd0) begin
                w_tx_next = {r_tx_shift[6:0], 1'b0};
            end else begin
                w_tx_next = miso_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt  <= 3'd0;
            r_first    <= 1'b1;
            r_rx_shift <= 7'd0;
            r_tx_shift <= 8'd0;
            r_data     <= 8'd0;
            r_strobe   <= 1'b0;
            r_start    <= 1'b0;
            r_miso     <= 1'b0;
        end else begin
            r_strobe   <= 1'b0;
            r_start    <= 1'b0;
            r_tx_shift <= w_tx_next;
            r_miso     <= w_csn_low & w_tx_next[7];
            // Deselect drops any partial byte and re-arms the start flag.
            if (!w_csn_low) begin
                r_bit_cnt <= 3'd0;
                r_first   <= 1'b1;
            end else if (r_rise) begin
                r_rx_shift <= {r_rx_shift[5:0], r_mosi_h};
                r_bit_cnt  <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_data   <= {r_rx_shift, r_mosi_h};
                    r_strobe <= 1'b1;
                    r_start  <= r_first;
                    r_first  <= 1'b0;
                end
            end
        end
    end

    assign data_out_strobe = r_strobe;
    assign data_out_start  = r_start;
    assign data_out        = r_data;
    assign spi_miso        = r_miso;

endmodule

// File: tb/tb_mcu_spi_slave.sv
// Directed bench for mcu_spi_slave: an MCU-side SPI driver, a strobe monitor that pops an
// expected {start,data} queue, and MISO capture checks.
module tb_mcu_spi_slave;

    logic       clk;
    logic       reset;
    logic       spi_csn;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;
    logic [7:0] miso_data;
    logic       data_out_strobe;
    logic       data_out_start;
    logic [7:0] data_out;

    logic [8:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_strobe = 0;

    mcu_spi_slave #(.SYNC_STAGES(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .spi_csn         (spi_csn),
        .spi_sclk        (spi_sclk),
        .spi_mosi        (spi_mosi),
        .spi_miso        (spi_miso),
        .miso_data       (miso_data),
        .data_out_strobe (data_out_strobe),
        .data_out_start  (data_out_start),
        .data_out        (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // SCLK = clk/8; MOSI changes with the falling edge, MISO sampled at the rising edge.
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'd0;
        for (int i = 0; i < n; i++) begin
            spi_sclk = 1'b0;
            spi_mosi = tx[7-i];
            tick(4);
            spi_sclk = 1'b1;
            rx = {rx[6:0], spi_miso};
            tick(4);
        end
    endtask

    task automatic csn_begin();
        spi_sclk = 1'b0;
        spi_csn  = 1'b0;
        tick(6);
    endtask

    task automatic csn_end(input int gap);
        spi_sclk = 1'b0;
        tick(4);
        spi_csn = 1'b1;
        tick(gap);
    endtask

    always @(negedge clk) begin
        if (data_out_strobe) begin
            logic [8:0] e;
            n_strobe++;
            check("strobe_expected", 16'(exp_q.size() != 0), 16'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("strobe_data", {8'd0, data_out}, {8'd0, e[7:0]});
                check("strobe_start", {15'd0, data_out_start}, {15'd0, e[8]});
            end
        end
        if (data_out_start) check("start_without_strobe", {15'd0, data_out_strobe}, 16'd1);
    end

    initial begin
        logic [7:0] rx;
        logic [7:0] b0;
        logic [7:0] b1;
        int base;

        reset     = 1'b1;
        spi_csn   = 1'b1;
        spi_sclk  = 1'b0;
        spi_mosi  = 1'b0;
        miso_data = 8'h00;
        tick(3);
        check("reset_strobe", {15'd0, data_out_strobe}, 16'd0);
        check("reset_start", {15'd0, data_out_start}, 16'd0);
        check("reset_data", {8'd0, data_out}, 16'd0);
        check("reset_miso", {15'd0, spi_miso}, 16'd0);
        reset = 1'b0;
        tick(2);

        // SCLK activity while deselected must not produce bytes.
        for (int i = 0; i < 16; i++) begin
            spi_sclk = 1'b1;
            tick(4);
            spi_sclk = 1'b0;
            tick(4);
        end
        tick(6);
        check("no_strobe_csn_high", 16'(n_strobe), 16'd0);
        check("miso_idle", {15'd0, spi_miso}, 16'd0);

        // OSD enable command.
        base = n_strobe;
        csn_begin();
        exp_q.push_back({1'b1, 8'h01});
        exp_q.push_back({1'b0, 8'h01});
        spi_bits(8'h01, 8, rx);
        spi_bits(8'h01, 8, rx);
        csn_end(4);
        tick(6);
        check("enable_strobes", 16'(n_strobe - base), 16'd2);

        // MISO readback: status byte loaded at select, next one at the byte boundary.
        base = n_strobe;
        miso_data = 8'hA5;
        csn_begin();
        exp_q.push_back({1'b1, 8'h02});
        exp_q.push_back({1'b0, 8'h00});
        spi_bits(8'h02, 8, rx);
        check("miso_byte0", {8'd0, rx}, 16'h00A5);
        miso_data = 8'h3C;
        spi_bits(8'h00, 8, rx);
        check("miso_byte1", {8'd0, rx}, 16'h003C);
        csn_end(4);
        tick(6);
        check("readback_strobes", 16'(n_strobe - base), 16'd2);
        check("miso_after_deselect", {15'd0, spi_miso}, 16'd0);

        // Abort after 5 bits, then a clean byte.
        base = n_strobe;
        csn_begin();
        spi_bits(8'hFF, 5, rx);
        csn_end(4);
        tick(6);
        check("abort_no_strobe", 16'(n_strobe - base), 16'd0);
        exp_q.push_back({1'b1, 8'h7E});
        csn_begin();
        spi_bits(8'h7E, 8, rx);
        csn_end(4);
        tick(6);
        check("abort_recover_strobes", 16'(n_strobe - base), 16'd1);

        // Back-to-back transactions with minimum deselect gap.
        base = n_strobe;
        for (int t = 0; t < 2; t++) begin
            b0 = 8'($urandom_range(0, 255));
            b1 = 8'($urandom_range(0, 255));
            csn_begin();
            exp_q.push_back({1'b1, b0});
            exp_q.push_back({1'b0, b1});
            spi_bits(b0, 8, rx);
            spi_bits(b1, 8, rx);
            csn_end(3);
        end
        tick(6);
        check("b2b_strobes", 16'(n_strobe - base), 16'd4);

        // Reset mid-byte with chip select held low.
        base = n_strobe;
        csn_begin();
        spi_bits(8'hA0, 4, rx);
        spi_sclk = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(6);
        exp_q.push_back({1'b1, 8'h55});
        spi_bits(8'h55, 8, rx);
        csn_end(4);
        tick(6);
        check("reset_mid_byte_strobes", 16'(n_strobe - base), 16'd1);
        check("data_held", {8'd0, data_out}, 16'h0055);
        check("strobe_idle", {15'd0, data_out_strobe}, 16'd0);
        check("queue_drained", 16'(exp_q.size()), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
